gpio_ctrl: RTL and testbench

- Multi-port GPIO controller: NUM_PORTS ports of DATA_WIDTH pins each, behind a single-cycle register bus.
- Drives separate pad output and output-enable vectors. The chip top builds the tristate buffers from them.
- Synchronises pad inputs and detects rising/falling edges per pin.
- Latches edges into write-1-to-clear flags and raises one registered interrupt line to the CPU.

---
 rtl/gpio_pkg.sv | 12 +
 rtl/gpio_port.sv | 55 +++++
 rtl/gpio_ctrl.sv | 60 ++++++
 tb/tb_gpio_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets and address field widths shared by the GPIO controller.
package gpio_pkg;
  localparam int PORT_SEL_W = 3;
  localparam int REG_SEL_W  = 3;
  localparam logic [REG_SEL_W-1:0] REG_DDR  = 3'd0;
  localparam logic [REG_SEL_W-1:0] REG_PORT = 3'd1;
  localparam logic [REG_SEL_W-1:0] REG_PIN  = 3'd2;
  localparam logic [REG_SEL_W-1:0] REG_RISE = 3'd3;
  localparam logic [REG_SEL_W-1:0] REG_FALL = 3'd4;
  localparam logic [REG_SEL_W-1:0] REG_IFR  = 3'd5;
  localparam logic [REG_SEL_W-1:0] REG_TGL  = 3'd6;
endpackage

// File: rtl/gpio_port.sv
// gpio_port: one GPIO port's registers, input synchroniser, edge detector and W1C flags.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [REG_SEL_W-1:0]  i_reg_sel,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_pad_in,
  output logic [DATA_WIDTH-1:0] o_rd_val,
  output logic [DATA_WIDTH-1:0] o_pad_out,
  output logic [DATA_WIDTH-1:0] o_pad_oe,
  output logic                  o_flag_any
);
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_sync;
  logic [DATA_WIDTH-1:0] r_ddr, r_port, r_rise_en, r_fall_en, r_ifr, r_prev;
  logic [DATA_WIDTH-1:0] w_pin, w_set, w_clr;
  assign w_pin = r_sync[SYNC_STAGES-1];
  assign w_set = (w_pin & ~r_prev & r_rise_en) | (~w_pin & r_prev & r_fall_en);
  assign w_clr = (i_we && i_reg_sel == REG_IFR) ? i_wdata : '0;
  // Set is ORed in after the clear so a same-cycle edge keeps its flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync    <= '0;
      r_prev    <= '0;
      r_ddr     <= '0;
      r_port    <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_ifr     <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad_in};
      r_prev <= w_pin;
      r_ifr  <= (r_ifr & ~w_clr) | w_set;
      if (i_we && i_reg_sel == REG_DDR)  r_ddr     <= i_wdata;
      if (i_we && i_reg_sel == REG_PORT) r_port    <= i_wdata;
      if (i_we && i_reg_sel == REG_TGL)  r_port    <= r_port ^ i_wdata;
      if (i_we && i_reg_sel == REG_RISE) r_rise_en <= i_wdata;
      if (i_we && i_reg_sel == REG_FALL) r_fall_en <= i_wdata;
    end
  end
  assign o_rd_val = i_reg_sel == REG_DDR  ? r_ddr :
                    i_reg_sel == REG_PORT ? r_port :
                    i_reg_sel == REG_PIN  ? w_pin :
                    i_reg_sel == REG_RISE ? r_rise_en :
                    i_reg_sel == REG_FALL ? r_fall_en :
                    i_reg_sel == REG_IFR  ? r_ifr : '0;
  assign o_pad_oe   = r_ddr;
  assign o_pad_out  = r_port & r_ddr;
  assign o_flag_any = |r_ifr;
endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: multi-port GPIO controller with register bus, read mux and combined interrupt.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_PORTS   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic                            we,
  input  logic                            re,
  output logic [DATA_WIDTH-1:0]           rdata,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] pad_in,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] pad_out,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] pad_oe,
  output logic                            irq
);
  logic [PORT_SEL_W-1:0] w_port_sel;
  logic [REG_SEL_W-1:0]  w_reg_sel;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_rd;
  logic [NUM_PORTS-1:0] w_flag;
  logic [DATA_WIDTH-1:0] w_rd_sel;
  assign w_port_sel = addr[ADDR_WIDTH-1 -: PORT_SEL_W];
  assign w_reg_sel  = addr[REG_SEL_W-1:0];
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    gpio_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_port (
      .clk       (clk),
      .reset     (reset),
      .i_we      (we && w_port_sel == PORT_SEL_W'(p)),
      .i_reg_sel (w_reg_sel),
      .i_wdata   (wdata),
      .i_pad_in  (pad_in[p*DATA_WIDTH +: DATA_WIDTH]),
      .o_rd_val  (w_rd[p]),
      .o_pad_out (pad_out[p*DATA_WIDTH +: DATA_WIDTH]),
      .o_pad_oe  (pad_oe[p*DATA_WIDTH +: DATA_WIDTH]),
      .o_flag_any(w_flag[p])
    );
  end
  // Port indices with no instance fall through to zero.
  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) w_rd_sel = (w_port_sel == PORT_SEL_W'(i)) ? w_rd[i] : w_rd_sel;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      if (re) rdata <= w_rd_sel;
      irq <= |w_flag;
    end
  end
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: randomized and directed bench for gpio_ctrl against a cycle-level register-map model.
module tb_gpio_ctrl;
  localparam int DW = 8, NP = 2, S = 2, AW = 6, W = NP * DW;

  logic clk = 1'b0, reset = 1'b0, we = 1'b0, re = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [W-1:0] pad_in = '0;
  logic [DW-1:0] rdata;
  logic [W-1:0] pad_out, pad_oe;
  logic irq;

  gpio_ctrl #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .SYNC_STAGES(S), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: register file per port plus a delay line of sampled pad values.
  logic [DW-1:0] m_ddr [NP], m_port [NP], m_ren [NP], m_fen [NP], m_ifr [NP];
  logic [W-1:0] m_hist [S+1];
  logic [DW-1:0] m_rdata, m_set, m_clr, m_pin, m_prev;
  logic m_irq, m_nirq;

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
    int p;
    p = int'(a[5:3]);
    if (p >= NP) return '0;
    case (a[2:0])
      3'd0: return m_ddr[p];
      3'd1: return m_port[p];
      3'd2: return m_hist[S-1][p*DW +: DW];
      3'd3: return m_ren[p];
      3'd4: return m_fen[p];
      3'd5: return m_ifr[p];
      default: return '0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        m_ddr[p] = '0; m_port[p] = '0; m_ren[p] = '0; m_fen[p] = '0; m_ifr[p] = '0;
      end
      for (int i = 0; i <= S; i++) m_hist[i] = '0;
      m_rdata = '0;
      m_irq = 1'b0;
    end else begin
      m_nirq = 1'b0;
      for (int p = 0; p < NP; p++) m_nirq = m_nirq | (m_ifr[p] != 0);
      if (re) m_rdata = mread(addr);
      for (int p = 0; p < NP; p++) begin
        m_pin  = m_hist[S-1][p*DW +: DW];
        m_prev = m_hist[S][p*DW +: DW];
        m_set  = (m_pin & ~m_prev & m_ren[p]) | (~m_pin & m_prev & m_fen[p]);
        m_clr  = '0;
        if (we && int'(addr[5:3]) == p) begin
          case (addr[2:0])
            3'd0: m_ddr[p] = wdata;
            3'd1: m_port[p] = wdata;
            3'd3: m_ren[p] = wdata;
            3'd4: m_fen[p] = wdata;
            3'd5: m_clr = wdata;
            3'd6: m_port[p] = m_port[p] ^ wdata;
            default: ;
          endcase
        end
        m_ifr[p] = (m_ifr[p] & ~m_clr) | m_set;
      end
      m_irq = m_nirq;
      for (int i = S; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = pad_in;
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial forever begin
    logic [W-1:0] e_out, e_oe;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      e_out[p*DW +: DW] = m_port[p] & m_ddr[p];
      e_oe[p*DW +: DW]  = m_ddr[p];
    end
    check("cyc_pad_out", pad_out, e_out);
    check("cyc_pad_oe", pad_oe, e_oe);
    check("cyc_irq", {{(W-1){1'b0}}, irq}, {{(W-1){1'b0}}, m_irq});
    check("cyc_rdata", {8'h00, rdata}, {8'h00, m_rdata});
  end

  function automatic logic [AW-1:0] A(input int p, input int r);
    return {3'(p), 3'(r)};
  endfunction

  task automatic bus_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = rdata;
  endtask

  logic [DW-1:0] rd;

  initial begin
    #2 reset = 1'b1;
    #1;
    check("rst_pad_out", pad_out, 16'h0000);
    check("rst_pad_oe", pad_oe, 16'h0000);
    check("rst_irq", {15'h0, irq}, 16'h0000);
    check("rst_rdata", {8'h0, rdata}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 16; a++) begin
      bus_rd(AW'(a), rd);
      check("rst_reg", {8'h0, rd}, 16'h0000);
    end
    bus_wr(A(1, 0), 8'hF0);
    bus_wr(A(1, 1), 8'hAA);
    check("out_pad_oe", {8'h0, pad_oe[15:8]}, 16'h00F0);
    check("out_pad_out", {8'h0, pad_out[15:8]}, 16'h00A0);
    bus_wr(A(1, 6), 8'hFF);
    check("tgl_pad_out", {8'h0, pad_out[15:8]}, 16'h0050);
    bus_rd(A(1, 1), rd);
    check("tgl_port", {8'h0, rd}, 16'h0055);
    bus_rd(A(1, 6), rd);
    check("tgl_reads0", {8'h0, rd}, 16'h0000);
    pad_in[3:0] = 4'h5;
    bus_rd(A(0, 2), rd);
    check("pin_early", {8'h0, rd}, 16'h0000);
    repeat (S - 1) @(negedge clk);
    bus_rd(A(0, 2), rd);
    check("pin_sync", {8'h0, rd}, 16'h0005);
    pad_in = '0;
    repeat (4) @(negedge clk);
    bus_wr(A(0, 3), 8'h01);
    pad_in[0] = 1'b1;
    repeat (S + 1) @(negedge clk);
    check("rise_irq_lo", {15'h0, irq}, 16'h0000);
    @(negedge clk);
    check("rise_irq_hi", {15'h0, irq}, 16'h0001);
    bus_rd(A(0, 5), rd);
    check("rise_ifr", {8'h0, rd}, 16'h0001);
    bus_wr(A(0, 5), 8'h01);
    check("w1c_irq_hold", {15'h0, irq}, 16'h0001);
    @(negedge clk);
    check("w1c_irq_lo", {15'h0, irq}, 16'h0000);
    pad_in[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("fall_noflag_irq", {15'h0, irq}, 16'h0000);
    bus_rd(A(0, 5), rd);
    check("fall_noflag_ifr", {8'h0, rd}, 16'h0000);
    bus_wr(A(0, 3), 8'h04);
    bus_wr(A(0, 4), 8'h04);
    pad_in[2] = 1'b1;
    repeat (5) @(negedge clk);
    check("coll_pre_irq", {15'h0, irq}, 16'h0001);
    pad_in[2] = 1'b0;
    repeat (S) @(negedge clk);
    bus_wr(A(0, 5), 8'h04);
    check("coll_model_ifr", {8'h0, m_ifr[0]}, 16'h0004);
    bus_rd(A(0, 5), rd);
    check("coll_ifr", {8'h0, rd}, 16'h0004);
    check("coll_irq", {15'h0, irq}, 16'h0001);
    bus_wr(A(0, 3), 8'h00);
    bus_wr(A(0, 4), 8'h00);
    bus_wr(A(0, 5), 8'hFF);
    bus_wr(A(5, 0), 8'hFF);
    bus_wr(A(5, 1), 8'hFF);
    bus_wr(A(0, 7), 8'hFF);
    check("oob_pad_oe", pad_oe, 16'hF000);
    bus_rd(A(5, 0), rd);
    check("oob_read", {8'h0, rd}, 16'h0000);
    bus_rd(A(0, 7), rd);
    check("rsvd_read", {8'h0, rd}, 16'h0000);
    repeat (600) begin
      we = ($urandom_range(0, 3) == 0);
      re = ($urandom_range(0, 1) == 0);
      addr = AW'($urandom);
      wdata = DW'($urandom);
      if ($urandom_range(0, 3) == 0) pad_in = W'($urandom);
      @(negedge clk);
    end
    we = 1'b0; re = 1'b0;
    repeat (4) @(negedge clk);
    bus_wr(A(0, 3), 8'hFF);
    bus_wr(A(0, 4), 8'hFF);
    bus_wr(A(0, 5), 8'hFF);
    pad_in[7:0] = ~pad_in[7:0];
    repeat (5) @(negedge clk);
    check("mid_model_ifr", {8'h0, m_ifr[0]}, 16'h00FF);
    check("mid_irq", {15'h0, irq}, 16'h0001);
    bus_rd(A(0, 5), rd);
    check("mid_ifr", {8'h0, rd}, 16'h00FF);
    bus_wr(A(1, 0), 8'hFF);
    bus_wr(A(1, 1), 8'h3C);
    addr = A(0, 5); wdata = 8'hFF; we = 1'b1; re = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("arst_pad_out", pad_out, 16'h0000);
    check("arst_pad_oe", pad_oe, 16'h0000);
    check("arst_irq", {15'h0, irq}, 16'h0000);
    check("arst_rdata", {8'h0, rdata}, 16'h0000);
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    reset = 1'b0;
    bus_rd(A(0, 5), rd);
    check("arst_ifr", {8'h0, rd}, 16'h0000);
    bus_rd(A(0, 3), rd);
    check("arst_rise_en", {8'h0, rd}, 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
